// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared defaults and FSM encoding for the RAM-backed FIFO controller
package ram_fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ADDR_W = 6;

  // IDLE may issue a RAM read; RD_WAIT is the cycle the RAM read data becomes valid
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/ram_fifo_outreg.sv
// rtl/ram_fifo_outreg.sv - registered FIFO head byte with hold-while-stalled behaviour
module ram_fifo_outreg
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  // Load on capture, drop valid on pop, otherwise hold data and valid unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (capture) begin
      rd_valid <= 1'b1;
      rd_data  <= cap_data;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller driving an external single-port synchronous RAM
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [WIDTH-1:0]  ram_input_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  input  logic [WIDTH-1:0]  ram_output_data
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              read_issue;
  logic              capture;
  logic              wr_accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and RAM port arbitration: a read-issue blocks writes for that cycle
  always_comb begin
    state_nxt   = state;
    read_issue  = 1'b0;
    capture     = 1'b0;
    wr_ready    = 1'b0;
    wr_accept   = 1'b0;
    ram_address = '0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          if ((ram_cnt != '0) && (!rd_valid || rd_ready)) begin
            read_issue  = 1'b1;
            ram_address = rd_ptr;
            state_nxt   = ST_RD_WAIT;
          end else begin
            wr_ready = (ram_cnt < DEPTH_CNT);
          end
        end
        ST_RD_WAIT: begin
          capture   = 1'b1;
          wr_ready  = (ram_cnt < DEPTH_CNT);
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
      wr_accept = wr_valid & wr_ready;
      if (wr_accept) ram_address = wr_ptr;
    end
  end

  // Pointers wrap naturally; occupancy moves by write accept minus capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (capture)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, capture})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  ram_fifo_outreg #(.WIDTH(WIDTH)) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .cap_data (ram_output_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign ram_we         = wr_accept;
  assign ram_input_data = wr_data;
  assign count          = ram_cnt + (ADDR_W+1)'(rd_valid);
  assign full           = (ram_cnt == DEPTH_CNT);
  assign empty          = (count == '0);

endmodule
